// File: rtl/key_click_decoder.sv
// key_click_decoder: classifies debounced short/long press pulses into single, double and long events
// and maintains the mode/value setting pair driven by those events.
module key_click_decoder #(
  parameter int CLK_FREQ    = 20_000_000,
  parameter int DOUBLE_TIME = 300,
  parameter int NUM_MODES   = 4,
  parameter int MODE_W      = 2,
  parameter int VAL_MAX     = 9,
  parameter int VAL_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_short_press,
  input  logic              key_long_press,
  output logic              evt_single,
  output logic              evt_double,
  output logic              evt_long,
  output logic [MODE_W-1:0] mode,
  output logic [VAL_W-1:0]  value
);
  localparam logic [31:0] DOUBLE_CNT = 32'(CLK_FREQ / 1000 * DOUBLE_TIME);
  typedef enum logic {IDLE, WAIT2} state_t;
  state_t state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic wait2, timeout, short_only;
  logic single_nx, double_nx, long_nx;
  logic [MODE_W-1:0] mode_nx;
  logic [VAL_W-1:0] value_nx;
  assign wait2      = state == WAIT2;
  assign timeout    = cnt == DOUBLE_CNT - 32'd1;
  assign short_only = key_short_press & ~key_long_press;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      evt_single <= 1'b0;
      evt_double <= 1'b0;
      evt_long   <= 1'b0;
      mode       <= '0;
      value      <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      evt_single <= single_nx;
      evt_double <= double_nx;
      evt_long   <= long_nx;
      mode       <= mode_nx;
      value      <= value_nx;
    end
  end
  // any press or the timeout closes the window; a long press alone never opens one
  always_comb begin
    state_nx = wait2 ? ((key_long_press | key_short_press | timeout) ? IDLE : WAIT2)
                     : (short_only ? WAIT2 : IDLE);
    cnt_nx   = (wait2 && state_nx == WAIT2) ? cnt + 32'd1 : '0;
  end
  // a long press flushes a pending single but its value reset overrides the increment
  always_comb begin
    long_nx   = key_long_press;
    double_nx = wait2 & short_only;
    single_nx = wait2 & (key_long_press | (~key_short_press & timeout));
    mode_nx   = key_long_press ? ((mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + 1'b1) : mode;
    value_nx  = key_long_press ? '0
              : double_nx ? ((value == '0) ? VAL_W'(VAL_MAX) : value - 1'b1)
              : single_nx ? ((value == VAL_W'(VAL_MAX)) ? '0 : value + 1'b1)
              : value;
  end
endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: directed scenarios with an event scoreboard keyed on the expected cycle
// of every event pulse together with the mode/value that must accompany it.
module tb_key_click_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_short_press = 1'b0;
  logic key_long_press = 1'b0;
  logic evt_single, evt_double, evt_long;
  logic [1:0] mode;
  logic [3:0] value;
  typedef struct {
    int at;
    logic s;
    logic d;
    logic l;
    logic [1:0] m;
    logic [3:0] v;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  key_click_decoder #(
    .CLK_FREQ(1000), .DOUBLE_TIME(10), .NUM_MODES(3), .MODE_W(2), .VAL_MAX(9), .VAL_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_short_press(key_short_press), .key_long_press(key_long_press),
    .evt_single(evt_single), .evt_double(evt_double), .evt_long(evt_long), .mode(mode), .value(value)
  );
  always #5 clk = ~clk;
  // advance one cycle and let the scoreboard consume any event seen in the new cycle
  task automatic advance();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (evt_single | evt_double | evt_long) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got s=%b d=%b l=%b mode=%0d value=%0d, none expected",
                 cyc, evt_single, evt_double, evt_long, mode, value);
      end else begin
        e = sb.pop_front();
        if ({e.at, e.s, e.d, e.l, e.m, e.v} !== {cyc, evt_single, evt_double, evt_long, mode, value}) begin
          miscompares++;
          $display("FAIL event cyc=%0d got s=%b d=%b l=%b mode=%0d value=%0d, expected cyc=%0d s=%b d=%b l=%b mode=%0d value=%0d",
                   cyc, evt_single, evt_double, evt_long, mode, value, e.at, e.s, e.d, e.l, e.m, e.v);
        end
      end
    end else if (sb.size() != 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event cyc=%0d got no pulse, expected s=%b d=%b l=%b at cyc=%0d",
               cyc, e.s, e.d, e.l, e.at);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) advance();
  endtask
  task automatic press(input bit s, input bit l);
    key_short_press = s;
    key_long_press = l;
    advance();
    key_short_press = 1'b0;
    key_long_press = 1'b0;
  endtask
  task automatic push(input int at, input bit s, input bit d, input bit l, input int m, input int v);
    sb.push_back('{at, s, d, l, 2'(m), 4'(v)});
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask
  task automatic test_reset();
    idle(3);
    vectors++;
    if ({evt_single, evt_double, evt_long} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_events got %b expected 000", {evt_single, evt_double, evt_long});
    end
    vectors++;
    if ({mode, value} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_regs got mode=%0d value=%0d expected 0 0", mode, value);
    end
    rst_n = 1'b1;
    idle(1);
    push(cyc + 1, 0, 0, 1, 1, 0);
    press(0, 1);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mode, evt_long} !== 3'd0) begin
      miscompares++;
      $display("FAIL async_reset got mode=%0d evt_long=%b expected 0 0", mode, evt_long);
    end
    idle(1);
    rst_n = 1'b1;
    idle(1);
  endtask
  task automatic test_single();
    int c;
    apply_reset();
    c = cyc;
    push(c + 11, 1, 0, 0, 0, 1);
    press(1, 0);
    idle(13);
    vectors++;
    if (value !== 4'd1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL single got value=%0d pending=%0d expected 1 0", value, sb.size());
    end
  endtask
  task automatic test_double();
    int c;
    apply_reset();
    c = cyc;
    push(c + 11, 0, 1, 0, 0, 9);
    press(1, 0);
    idle(9);
    press(1, 0);
    idle(12);
    vectors++;
    if (value !== 4'd9 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL double_boundary got value=%0d pending=%0d expected 9 0", value, sb.size());
    end
    apply_reset();
    c = cyc;
    push(c + 11, 1, 0, 0, 0, 1);
    press(1, 0);
    idle(10);
    push(c + 22, 1, 0, 0, 0, 2);
    press(1, 0);
    idle(12);
    vectors++;
    if (value !== 4'd2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL late_second_press got value=%0d pending=%0d expected 2 0", value, sb.size());
    end
  endtask
  task automatic test_wrap();
    int c;
    apply_reset();
    c = cyc;
    push(c + 2, 0, 1, 0, 0, 9);
    press(1, 0);
    press(1, 0);
    idle(2);
    c = cyc;
    push(c + 11, 1, 0, 0, 0, 0);
    press(1, 0);
    idle(11);
    vectors++;
    if (value !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_up got value=%0d expected 0", value);
    end
    c = cyc;
    push(c + 2, 0, 1, 0, 0, 9);
    press(1, 0);
    press(1, 0);
    idle(2);
    vectors++;
    if (value !== 4'd9 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_down got value=%0d pending=%0d expected 9 0", value, sb.size());
    end
  endtask
  task automatic test_long();
    int c;
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      push(cyc + 1, 0, 0, 1, i % 3, 0);
      press(0, 1);
      idle(1);
    end
    vectors++;
    if (mode !== 2'd0) begin
      miscompares++;
      $display("FAIL mode_cycle got mode=%0d expected 0", mode);
    end
    for (int i = 1; i <= 5; i++) begin
      push(cyc + 11, 1, 0, 0, 0, i);
      press(1, 0);
      idle(10);
    end
    push(cyc + 1, 0, 0, 1, 1, 0);
    press(0, 1);
    idle(1);
    vectors++;
    if ({mode, value} !== {2'd1, 4'd0}) begin
      miscompares++;
      $display("FAIL long_clears_value got mode=%0d value=%0d expected 1 0", mode, value);
    end
    c = cyc;
    push(c + 1, 0, 0, 1, 2, 0);
    press(1, 1);
    idle(13);
    vectors++;
    if ({mode, value} !== {2'd2, 4'd0} || sb.size() != 0) begin
      miscompares++;
      $display("FAIL both_in_idle got mode=%0d value=%0d pending=%0d expected 2 0 0", mode, value, sb.size());
    end
  endtask
  task automatic test_long_in_window();
    int c;
    apply_reset();
    c = cyc;
    push(c + 5, 1, 0, 1, 1, 0);
    press(1, 0);
    idle(3);
    press(0, 1);
    idle(12);
    vectors++;
    if ({mode, value} !== {2'd1, 4'd0} || sb.size() != 0) begin
      miscompares++;
      $display("FAIL long_in_window got mode=%0d value=%0d pending=%0d expected 1 0 0", mode, value, sb.size());
    end
    c = cyc;
    push(c + 3, 1, 0, 1, 2, 0);
    press(1, 0);
    idle(1);
    press(1, 1);
    idle(13);
    vectors++;
    if ({mode, value} !== {2'd2, 4'd0} || sb.size() != 0) begin
      miscompares++;
      $display("FAIL both_in_window got mode=%0d value=%0d pending=%0d expected 2 0 0", mode, value, sb.size());
    end
  endtask
  task automatic test_reset_in_window();
    int c;
    apply_reset();
    push(cyc + 1, 0, 0, 1, 1, 0);
    press(0, 1);
    push(cyc + 11, 1, 0, 0, 1, 1);
    press(1, 0);
    idle(10);
    c = cyc;
    press(1, 0);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(15);
    vectors++;
    if ({mode, value} !== 6'd0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL reset_in_window got mode=%0d value=%0d pending=%0d expected 0 0 0 (press at %0d)",
               mode, value, sb.size(), c);
    end
    push(cyc + 11, 1, 0, 0, 0, 1);
    press(1, 0);
    idle(12);
    vectors++;
    if (value !== 4'd1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL single_after_reset got value=%0d pending=%0d expected 1 0", value, sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_double();
    test_wrap();
    test_long();
    test_long_in_window();
    test_reset_in_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
- Sits directly downstream of the key debounce stage. It consumes that stage's one-cycle short-press and long-press pulses and classifies them into single-click, double-click and long-press events.
- Owns a small user-setting register pair used by the display and control logic:
  - mode: cycled by a long press.
  - value: incremented by a single click, decremented by a double click.

Parameters:
- CLK_FREQ, 20_000_000: clock frequency in Hz.
- DOUBLE_TIME, 300: double-click window in ms.
- NUM_MODES, 4: number of modes. Legal range 2..2^MODE_W.
- MODE_W, 2: width of the mode output.
- VAL_MAX, 9: maximum value. Value range is 0..VAL_MAX.
- VAL_W, 4: width of the value output. Must satisfy VAL_MAX < 2^VAL_W.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- key_short_press, input, 1: one-cycle short-press pulse from the debounce stage.
- key_long_press, input, 1: one-cycle long-press pulse from the debounce stage.
- evt_single, output, 1: one-cycle pulse, single click resolved.
- evt_double, output, 1: one-cycle pulse, double click resolved.
- evt_long, output, 1: one-cycle pulse, long press forwarded.
- mode, output, MODE_W: current mode index.
- value, output, VAL_W: current value within the mode.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, window counter=0.
  - evt_single, evt_double and evt_long = 0.
  - mode=0, value=0.
  - Reset asserted mid-window discards the pending click; no event is emitted.
- Window length: DOUBLE_CNT = CLK_FREQ/1000*DOUBLE_TIME cycles. The window counter is 32 bits.
- Pulse rules:
  - All outputs are registered.
  - Event pulses are exactly one cycle wide.
  - mode and value update on the same edge that raises the corresponding event pulse.
- Timing reference: the input pulse is high in cycle 0.
- State IDLE:
  - key_long_press: evt_long high in cycle 1; stay IDLE.
  - key_short_press (without long): go to WAIT2 in cycle 1 with counter=0.
- State WAIT2, where the counter = k-1 in cycle k:
  - key_short_press in any cycle 1..DOUBLE_CNT: evt_double high the next cycle; go to IDLE.
  - No short press and counter==DOUBLE_CNT-1 (cycle DOUBLE_CNT): evt_single high in cycle DOUBLE_CNT+1; go to IDLE.
  - A short press on the timeout cycle counts as a double click; short wins over timeout.
  - key_long_press: evt_single and evt_long both high the next cycle; go to IDLE.
- Simultaneous key_short_press and key_long_press in one cycle:
  - The long press has priority and the short press is ignored.
  - The rule applies in either state; in WAIT2 the pending single is still flushed.
- A short press arriving the cycle evt_single is high (state now IDLE) starts a new window.
- Value arithmetic:
  - evt_single: value = (value==VAL_MAX) ? 0 : value+1.
  - evt_double: value = (value==0) ? VAL_MAX : value-1.
- Mode arithmetic:
  - evt_long: mode = (mode==NUM_MODES-1) ? 0 : mode+1, and value=0.
  - When a long press coincides with a flushed single, the mode change wins: value=0 and the increment is discarded.
- Quiescent behaviour: no other state change occurs; mode and value hold indefinitely.

Test Plan:
All directed tests override CLK_FREQ=1000, DOUBLE_TIME=10 (so DOUBLE_CNT=10), NUM_MODES=3, VAL_MAX=9.
1. Single click: after reset, short press in cycle 0 and no further input.
   - evt_single high only in cycle 11; value 0->1 in cycle 11; evt_double and evt_long never high.
2. Double click: short presses in cycle 0 and cycle 10 (the boundary cycle).
   - evt_double high in cycle 11, value 0->9 (wrap); no evt_single.
   - Repeat with the second press in cycle 11: evt_single in cycle 11, then a new window opens.
3. Value wrap: from value=9, a single click gives value=0. From value=0, a double click gives value=9.
4. Long press:
   - Three long pulses cycle mode 0->1->2->0, each with evt_long high for one cycle.
   - With value=5 beforehand, a long press forces value to 0.
5. Long press during window: short in cycle 0, long in cycle 4.
   - evt_single and evt_long both high in cycle 5; mode+1; value=0; state returns to IDLE.
6. Reset mid-window: short in cycle 0, rst_n low in cycles 3-4.
   - No event pulse ever; mode=0, value=0.
   - A fresh short press after reset gives a normal single-click result.
